icache_prefetch_arbiter: RTL and testbench

- Owns the single ICache request port.
- Arbitrates between fetch demand misses and a sequential next-line prefetcher.
- Holds one prefetched 128-bit line in a buffer, so a sequential demand that hits the buffer gets its response with no ICache round trip.
- Sits between the fetch-side icache_interface and the ICache/TLB; at most one ICache request is outstanding at any time.

---
 rtl/icache_prefetch_arbiter.sv | 166 ++++++++++++++++
 tb/tb_icache_prefetch_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_prefetch_arbiter.sv
// Owns the ICache request port: demand misses beat a sequential next-line prefetcher, and one line is buffered.
// Buffer hits answer in the same cycle; one ICache request is in flight at most; requests issue only with icache_req_ready_i.
module icache_prefetch_arbiter #(
    parameter int ADDR_W = 40,
    parameter int LINE_W = 128,
    parameter int OFF_W  = 4,
    parameter int PAGE_W = 12
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     dmd_valid_i,
    input  logic [ADDR_W-1:0]        dmd_vaddr_i,
    input  logic                     dmd_kill_i,
    input  logic                     flush_i,
    input  logic                     pf_enable_i,
    output logic                     dmd_resp_valid_o,
    output logic [LINE_W-1:0]        dmd_resp_data_o,
    output logic                     dmd_resp_xcpt_o,
    input  logic                     icache_req_ready_i,
    output logic                     icache_req_valid_o,
    output logic [PAGE_W-1:0]        icache_req_bits_idx_o,
    output logic [ADDR_W-PAGE_W-1:0] icache_req_bits_vpn_o,
    output logic                     icache_req_kill_o,
    input  logic                     icache_resp_valid_i,
    input  logic [ADDR_W-1:0]        icache_resp_vaddr_i,
    input  logic [LINE_W-1:0]        icache_resp_datablock_i,
    input  logic                     tlb_resp_xcp_if_i,
    output logic                     pf_issue_o,
    output logic                     pf_hit_o
);
    localparam int LN_W = ADDR_W - OFF_W;
    localparam int PL_W = PAGE_W - OFF_W;

    typedef enum logic [1:0] {IDLE, DMD_WAIT, PF_WAIT} state_e;

    state_e            state_q, state_d;
    logic [LN_W-1:0]   req_line_q, req_line_d;
    logic [LN_W-1:0]   pf_line_q, pf_line_d;
    logic [LN_W-1:0]   buf_line_q, buf_line_d;
    logic              pf_pend_q, pf_pend_d;
    logic              buf_valid_q, buf_valid_d;
    logic [LINE_W-1:0] buf_data_q, buf_data_d;

    logic [LN_W-1:0] dmd_line, rsp_line, sched_src, issue_line;
    logic dmd_held, dmd_live, buf_hit, dmd_issue, pf_fire, rsp_hit;
    logic dw_abort, dw_done, pw_abort, pw_done, rsp_to_dmd, sched;
    logic unused_offsets;

    assign dmd_line = dmd_vaddr_i[ADDR_W-1:OFF_W];
    assign rsp_line = icache_resp_vaddr_i[ADDR_W-1:OFF_W];
    assign unused_offsets = ^{dmd_vaddr_i[OFF_W-1:0], icache_resp_vaddr_i[OFF_W-1:0]};

    assign dmd_held  = dmd_valid_i & ~dmd_kill_i;
    assign dmd_live  = dmd_held & ~flush_i;
    assign buf_hit   = (state_q == IDLE) & dmd_live & buf_valid_q & (dmd_line == buf_line_q);
    assign dmd_issue = (state_q == IDLE) & dmd_live & ~buf_hit & icache_req_ready_i;
    assign pf_fire   = (state_q == IDLE) & ~flush_i & ~dmd_held & pf_pend_q
                     & pf_enable_i & icache_req_ready_i;
    assign rsp_hit   = icache_resp_valid_i & (rsp_line == req_line_q);

    // A kill or redirect outranks a response landing in the same cycle.
    assign dw_abort   = (state_q == DMD_WAIT)
                      & (flush_i | dmd_kill_i | (dmd_valid_i & (dmd_line != req_line_q)));
    assign dw_done    = (state_q == DMD_WAIT) & ~dw_abort & rsp_hit;
    assign pw_abort   = (state_q == PF_WAIT) & (flush_i | (dmd_live & (dmd_line != req_line_q)));
    assign pw_done    = (state_q == PF_WAIT) & ~pw_abort & rsp_hit;
    assign rsp_to_dmd = dw_done | (pw_done & dmd_live);

    // Next-line prefetch is never scheduled across a page boundary.
    assign sched_src  = buf_hit ? buf_line_q : req_line_q;
    assign sched      = (buf_hit | (rsp_to_dmd & ~tlb_resp_xcp_if_i)) & ~(&sched_src[PL_W-1:0]);
    assign issue_line = dmd_issue ? dmd_line : pf_line_q;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (dmd_issue) state_d = DMD_WAIT;
                      else if (pf_fire) state_d = PF_WAIT;
            DMD_WAIT: if (dw_abort | dw_done) state_d = IDLE;
            PF_WAIT:  if (pw_abort | pw_done) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        dmd_resp_valid_o      = 1'b0;
        dmd_resp_data_o       = {LINE_W{1'b0}};
        dmd_resp_xcpt_o       = 1'b0;
        icache_req_valid_o    = 1'b0;
        icache_req_bits_idx_o = {PAGE_W{1'b0}};
        icache_req_bits_vpn_o = {(ADDR_W-PAGE_W){1'b0}};
        icache_req_kill_o     = 1'b0;
        pf_issue_o            = 1'b0;
        pf_hit_o              = 1'b0;
        if (rstn_i) begin
            dmd_resp_valid_o = buf_hit | rsp_to_dmd;
            if (buf_hit) begin
                dmd_resp_data_o = buf_data_q;
            end else if (rsp_to_dmd & ~tlb_resp_xcp_if_i) begin
                dmd_resp_data_o = icache_resp_datablock_i;
            end
            dmd_resp_xcpt_o    = rsp_to_dmd & tlb_resp_xcp_if_i;
            icache_req_valid_o = dmd_issue | pf_fire;
            if (dmd_issue | pf_fire) begin
                icache_req_bits_idx_o = {issue_line[PL_W-1:0], {OFF_W{1'b0}}};
                icache_req_bits_vpn_o = issue_line[LN_W-1:PL_W];
            end
            icache_req_kill_o = dw_abort | pw_abort;
            pf_issue_o        = pf_fire;
            pf_hit_o          = buf_hit;
        end
    end

    always_comb begin
        req_line_d  = req_line_q;
        pf_line_d   = pf_line_q;
        pf_pend_d   = pf_pend_q;
        buf_line_d  = buf_line_q;
        buf_data_d  = buf_data_q;
        buf_valid_d = buf_valid_q;
        if (dmd_issue) req_line_d = dmd_line;
        if (pf_fire) begin
            req_line_d = pf_line_q;
            pf_pend_d  = 1'b0;
        end
        if (sched) begin
            pf_pend_d = 1'b1;
            pf_line_d = sched_src + LN_W'(1);
        end
        if (pw_done & ~tlb_resp_xcp_if_i) begin
            buf_valid_d = 1'b1;
            buf_line_d  = req_line_q;
            buf_data_d  = icache_resp_datablock_i;
        end
        if (flush_i) begin
            buf_valid_d = 1'b0;
            pf_pend_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            req_line_q  <= '0;
            pf_line_q   <= '0;
            pf_pend_q   <= 1'b0;
            buf_valid_q <= 1'b0;
            buf_line_q  <= '0;
            buf_data_q  <= '0;
        end else begin
            req_line_q  <= req_line_d;
            pf_line_q   <= pf_line_d;
            pf_pend_q   <= pf_pend_d;
            buf_valid_q <= buf_valid_d;
            buf_line_q  <= buf_line_d;
            buf_data_q  <= buf_data_d;
        end
    end
endmodule

// File: tb/tb_icache_prefetch_arbiter.sv
// Directed scenarios plus randomized traffic, every cycle compared against a transaction-level model.
module tb_icache_prefetch_arbiter;
    localparam int ADDR_W = 40;
    localparam int LINE_W = 128;
    localparam int LN_W   = 36;

    logic              clk_i = 1'b0;
    logic              rstn_i, dmd_valid_i, dmd_kill_i, flush_i, pf_enable_i;
    logic [ADDR_W-1:0] dmd_vaddr_i, icache_resp_vaddr_i;
    logic              icache_req_ready_i, icache_resp_valid_i, tlb_resp_xcp_if_i;
    logic [LINE_W-1:0] icache_resp_datablock_i, dmd_resp_data_o;
    logic              dmd_resp_valid_o, dmd_resp_xcpt_o, icache_req_valid_o, icache_req_kill_o;
    logic [11:0]       icache_req_bits_idx_o;
    logic [27:0]       icache_req_bits_vpn_o;
    logic              pf_issue_o, pf_hit_o;

    always #5 clk_i = ~clk_i;

    icache_prefetch_arbiter dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .dmd_valid_i(dmd_valid_i), .dmd_vaddr_i(dmd_vaddr_i),
        .dmd_kill_i(dmd_kill_i), .flush_i(flush_i), .pf_enable_i(pf_enable_i),
        .dmd_resp_valid_o(dmd_resp_valid_o), .dmd_resp_data_o(dmd_resp_data_o),
        .dmd_resp_xcpt_o(dmd_resp_xcpt_o), .icache_req_ready_i(icache_req_ready_i),
        .icache_req_valid_o(icache_req_valid_o), .icache_req_bits_idx_o(icache_req_bits_idx_o),
        .icache_req_bits_vpn_o(icache_req_bits_vpn_o), .icache_req_kill_o(icache_req_kill_o),
        .icache_resp_valid_i(icache_resp_valid_i), .icache_resp_vaddr_i(icache_resp_vaddr_i),
        .icache_resp_datablock_i(icache_resp_datablock_i), .tlb_resp_xcp_if_i(tlb_resp_xcp_if_i),
        .pf_issue_o(pf_issue_o), .pf_hit_o(pf_hit_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: what is outstanding at the ICache, the buffered line and the pending prefetch.
    int                m_busy = 0;   // 0 nothing outstanding, 1 demand fetch, 2 prefetch
    logic [LN_W-1:0]   m_line = '0, m_pf_line = '0, m_buf_line = '0;
    bit                m_pf_pend = 0, m_buf_v = 0;
    logic [LINE_W-1:0] m_buf_data = '0;

    bit              o_resp = 0, o_req_v = 0, o_kill = 0;
    logic [LN_W-1:0] o_req_line = '0;

    task automatic model_cycle();
        bit rv = 0, x = 0, qv = 0, k = 0, pi = 0, ph = 0, sched = 0, held, rsp_match;
        logic [LINE_W-1:0] d = '0;
        logic [LN_W-1:0]   ql = '0, src = '0, dl, rl;
        dl = dmd_vaddr_i[ADDR_W-1:4];
        rl = icache_resp_vaddr_i[ADDR_W-1:4];
        if (!rstn_i) begin
            m_busy = 0; m_pf_pend = 0; m_buf_v = 0;
            check("rst_resp_v", dmd_resp_valid_o, 0);
            check("rst_resp_data", dmd_resp_data_o, 0);
            check("rst_xcpt", dmd_resp_xcpt_o, 0);
            check("rst_req_v", icache_req_valid_o, 0);
            check("rst_idx", icache_req_bits_idx_o, 0);
            check("rst_vpn", icache_req_bits_vpn_o, 0);
            check("rst_kill", icache_req_kill_o, 0);
            check("rst_pf_issue", pf_issue_o, 0);
            check("rst_pf_hit", pf_hit_o, 0);
        end else begin
            held      = dmd_valid_i && !dmd_kill_i;
            rsp_match = icache_resp_valid_i && (rl == m_line);
            if (m_busy == 0) begin
                if (!flush_i) begin
                    if (held && m_buf_v && dl == m_buf_line) begin
                        rv = 1; d = m_buf_data; ph = 1; sched = 1; src = m_buf_line;
                    end else if (held) begin
                        if (icache_req_ready_i) begin
                            qv = 1; ql = dl; m_busy = 1; m_line = dl;
                        end
                    end else if (m_pf_pend && pf_enable_i && icache_req_ready_i) begin
                        qv = 1; ql = m_pf_line; pi = 1; m_pf_pend = 0; m_busy = 2; m_line = m_pf_line;
                    end
                end
            end else if (m_busy == 1) begin
                if (flush_i || dmd_kill_i || (dmd_valid_i && dl != m_line)) begin
                    k = 1; m_busy = 0;
                end else if (rsp_match) begin
                    rv = 1; x = tlb_resp_xcp_if_i; d = x ? '0 : icache_resp_datablock_i;
                    sched = !x; src = m_line; m_busy = 0;
                end
            end else begin
                if (flush_i || (held && dl != m_line)) begin
                    k = 1; m_busy = 0;
                end else if (rsp_match) begin
                    if (!tlb_resp_xcp_if_i) begin
                        m_buf_v = 1; m_buf_line = m_line; m_buf_data = icache_resp_datablock_i;
                    end
                    if (held) begin
                        rv = 1; x = tlb_resp_xcp_if_i; d = x ? '0 : icache_resp_datablock_i;
                        sched = !x; src = m_line;
                    end
                    m_busy = 0;
                end
            end
            if (flush_i) begin
                m_buf_v = 0; m_pf_pend = 0;
            end
            if (sched && src[7:0] != 8'hFF) begin
                m_pf_pend = 1; m_pf_line = src + 36'd1;
            end
            check("resp_v", dmd_resp_valid_o, rv);
            if (rv) check("resp_data", dmd_resp_data_o, d);
            check("xcpt", dmd_resp_xcpt_o, x);
            check("req_v", icache_req_valid_o, qv);
            if (qv) begin
                check("req_idx", icache_req_bits_idx_o, {ql[7:0], 4'h0});
                check("req_vpn", icache_req_bits_vpn_o, ql[35:8]);
            end
            check("kill", icache_req_kill_o, k);
            check("pf_issue", pf_issue_o, pi);
            check("pf_hit", pf_hit_o, ph);
        end
        o_resp = dmd_resp_valid_o; o_req_v = icache_req_valid_o; o_kill = icache_req_kill_o;
        o_req_line = {icache_req_bits_vpn_o, icache_req_bits_idx_o[11:4]};
    endtask

    always @(negedge clk_i) model_cycle();

    logic [LINE_W-1:0] dat [0:15];

    task automatic tick();
        @(posedge clk_i);
        #1;
        icache_resp_valid_i = 0; tlb_resp_xcp_if_i = 0; dmd_kill_i = 0; flush_i = 0;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic rsp(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d, input bit x);
        icache_resp_valid_i = 1; icache_resp_vaddr_i = a; icache_resp_datablock_i = d; tlb_resp_xcp_if_i = x;
    endtask

    bit              act = 0, ic_pend = 0, killed = 0;
    logic [ADDR_W-1:0] act_addr = '0, last_addr = 40'h8020;
    logic [LN_W-1:0] ic_line = '0;
    int              ic_cnt = 0;

    initial begin
        for (int i = 0; i < 16; i++) dat[i] = {4{32'(32'hC0DE_0000 + i)}};
        rstn_i = 0; dmd_valid_i = 0; dmd_vaddr_i = '0; dmd_kill_i = 0; flush_i = 0; pf_enable_i = 1;
        icache_req_ready_i = 1; icache_resp_valid_i = 0; icache_resp_vaddr_i = '0;
        icache_resp_datablock_i = '0; tlb_resp_xcp_if_i = 0;
        tick(); dmd_valid_i = 1; dmd_vaddr_i = 40'h1000; settle();
        check("t0_rst_req_v", icache_req_valid_o, 0);
        check("t0_rst_resp_v", dmd_resp_valid_o, 0);

        // Demand miss, response, then sequential prefetch.
        tick(); rstn_i = 1; settle();
        check("t1_req_v", icache_req_valid_o, 1);
        check("t1_req_vpn", icache_req_bits_vpn_o, 28'h1);
        check("t1_req_idx", icache_req_bits_idx_o, 12'h000);
        tick(); settle(); check("t1_wait_no_req", icache_req_valid_o, 0);
        tick(); rsp(40'h1000, dat[1], 0); settle();
        check("t1_resp_v", dmd_resp_valid_o, 1);
        check("t1_resp_data", dmd_resp_data_o, dat[1]);
        tick(); dmd_valid_i = 0; settle();
        check("t1_pf_issue", pf_issue_o, 1);
        check("t1_pf_idx", icache_req_bits_idx_o, 12'h010);
        tick(); rsp(40'h1010, dat[2], 0); settle();
        check("t1_fill_no_resp", dmd_resp_valid_o, 0);

        // Buffer hit.
        tick(); dmd_valid_i = 1; dmd_vaddr_i = 40'h1014; settle();
        check("t2_hit_resp_v", dmd_resp_valid_o, 1);
        check("t2_hit_data", dmd_resp_data_o, dat[2]);
        check("t2_pf_hit", pf_hit_o, 1);
        check("t2_hit_no_req", icache_req_valid_o, 0);
        tick(); dmd_valid_i = 0; settle();
        check("t2_pf_issue", pf_issue_o, 1);
        check("t2_pf_idx", icache_req_bits_idx_o, 12'h020);
        tick(); rsp(40'h1020, dat[3], 0); settle();

        // Last line of a page: no prefetch follows.
        tick(); dmd_valid_i = 1; dmd_vaddr_i = 40'h1FF0; settle();
        check("t3_req_idx", icache_req_bits_idx_o, 12'hFF0);
        tick(); rsp(40'h1FF0, dat[4], 0); settle();
        check("t3_resp_v", dmd_resp_valid_o, 1);
        for (int i = 0; i < 3; i++) begin
            tick(); dmd_valid_i = 0; settle();
            check("t3_no_pf", icache_req_valid_o, 0);
        end

        // Redirect during an in-flight prefetch.
        tick(); dmd_valid_i = 1; dmd_vaddr_i = 40'h2000; settle();
        tick(); rsp(40'h2000, dat[5], 0); settle();
        tick(); dmd_valid_i = 0; settle();
        check("t4_pf_issue", pf_issue_o, 1);
        check("t4_pf_vpn", icache_req_bits_vpn_o, 28'h2);
        tick(); dmd_valid_i = 1; dmd_vaddr_i = 40'h8000; settle();
        check("t4_kill", icache_req_kill_o, 1);
        check("t4_kill_no_req", icache_req_valid_o, 0);
        tick(); rsp(40'h2010, dat[6], 0); settle();
        check("t4_reissue", icache_req_valid_o, 1);
        check("t4_reissue_vpn", icache_req_bits_vpn_o, 28'h8);
        check("t4_stale_ignored", dmd_resp_valid_o, 0);
        tick(); rsp(40'h8000, dat[7], 0); settle();
        check("t4_resp_data", dmd_resp_data_o, dat[7]);
        tick(); dmd_valid_i = 0; settle();
        tick(); rsp(40'h8010, dat[8], 0); settle();

        // Exception response, then flush during a prefetch.
        tick(); dmd_valid_i = 1; dmd_vaddr_i = 40'h3000; settle();
        tick(); rsp(40'h3000, dat[9], 1); settle();
        check("t5_xcpt_v", dmd_resp_valid_o, 1);
        check("t5_xcpt", dmd_resp_xcpt_o, 1);
        check("t5_xcpt_data", dmd_resp_data_o, 0);
        tick(); dmd_valid_i = 0; settle();
        check("t5_xcpt_no_pf", icache_req_valid_o, 0);
        tick(); dmd_valid_i = 1; dmd_vaddr_i = 40'h4000; settle();
        tick(); rsp(40'h4000, dat[10], 0); settle();
        tick(); dmd_valid_i = 0; settle();
        check("t5_pf_issue", pf_issue_o, 1);
        tick(); flush_i = 1; settle();
        check("t5_flush_kill", icache_req_kill_o, 1);
        tick(); dmd_valid_i = 1; dmd_vaddr_i = 40'h8018; settle();
        check("t5_flushed_miss", icache_req_valid_o, 1);
        check("t5_flushed_no_hit", pf_hit_o, 0);
        tick(); rsp(40'h8010, dat[11], 0); settle();
        check("t5_resp_data", dmd_resp_data_o, dat[11]);
        tick(); dmd_valid_i = 0; settle();
        tick(); rsp(40'h8020, dat[12], 0); settle();

        // Reset in the middle of a demand fetch.
        tick(); dmd_valid_i = 1; dmd_vaddr_i = 40'h5000; settle();
        check("t6_req_v", icache_req_valid_o, 1);
        tick(); rstn_i = 0; rsp(40'h5000, dat[13], 0); settle();
        check("t6_rst_resp_v", dmd_resp_valid_o, 0);
        check("t6_rst_resp_data", dmd_resp_data_o, 0);
        check("t6_rst_kill", icache_req_kill_o, 0);
        tick(); dmd_valid_i = 0; settle();
        tick(); rstn_i = 1; dmd_valid_i = 1; dmd_vaddr_i = 40'h8020; settle();
        check("t6_buf_gone_req", icache_req_valid_o, 1);
        check("t6_buf_gone_idx", icache_req_bits_idx_o, 12'h020);
        check("t6_buf_gone_hit", pf_hit_o, 0);
        tick(); rsp(40'h8020, dat[14], 0); settle();
        check("t6_resp_data", dmd_resp_data_o, dat[14]);
        tick(); dmd_valid_i = 0; settle();

        // Randomized traffic against a simple ICache responder.
        for (int c = 0; c < 4000; c++) begin
            tick();
            if (o_kill && $urandom_range(0, 1) == 0) ic_pend = 0;
            if (o_req_v) begin
                ic_pend = 1; ic_line = o_req_line; ic_cnt = $urandom_range(0, 3);
            end
            if (ic_pend) begin
                if (ic_cnt == 0) begin
                    rsp({ic_line, 4'($urandom_range(0, 15))}, {$urandom, $urandom, $urandom, $urandom},
                        $urandom_range(0, 7) == 0);
                    ic_pend = 0;
                end else begin
                    ic_cnt--;
                end
            end
            if (act && (o_resp || killed)) act = 0;
            killed = 0;
            if (!act && $urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4: act_addr = last_addr + 40'd16;
                    5, 6:          act_addr = last_addr;
                    7:             act_addr = {28'($urandom_range(1, 4)), 12'hFF0};
                    default:       act_addr = {28'($urandom_range(1, 4)), 12'($urandom)};
                endcase
                act_addr[3:0] = 4'($urandom_range(0, 15));
                last_addr = act_addr;
                act = 1;
            end
            dmd_valid_i = act;
            if (act) dmd_vaddr_i = act_addr;
            if (act && $urandom_range(0, 29) == 0) begin
                dmd_kill_i = 1; killed = 1;
            end
            flush_i            = ($urandom_range(0, 59) == 0);
            pf_enable_i        = ($urandom_range(0, 9) != 0);
            icache_req_ready_i = ($urandom_range(0, 9) != 0);
            rstn_i             = ($urandom_range(0, 499) != 0);
        end
        tick(); dmd_valid_i = 0; rstn_i = 1;
        tick(); settle();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
